// File: rtl/controller_hub_if.sv
// Pad-bus and handshake bundle for controller_hub_m.
// The master side drives tick, requests, pad data and clears; the slave side is the poller.
interface controller_hub_if #(
    parameter int unsigned NUM_CONTROLLERS = 2,
    parameter int unsigned BUTTONS         = 8
);
    localparam int unsigned NB = NUM_CONTROLLERS * BUTTONS;

    logic                       clk_in_enable;
    logic                       poll_start;
    logic                       controller_latch;
    logic                       controller_clk_out_enable;
    logic [NUM_CONTROLLERS-1:0] data_in_B;
    logic [NB-1:0]              buttons_out;
    logic [NB-1:0]              pressed_out;
    logic [NUM_CONTROLLERS-1:0] clear;
    logic                       busy;
    logic                       poll_done;

    modport master (
        output clk_in_enable, poll_start, data_in_B, clear,
        input  controller_latch, controller_clk_out_enable, buttons_out, pressed_out, busy, poll_done
    );

    modport slave (
        input  clk_in_enable, poll_start, data_in_B, clear,
        output controller_latch, controller_clk_out_enable, buttons_out, pressed_out, busy, poll_done
    );
endinterface

// File: rtl/controller_hub_m.sv
// Serial game-controller poller: latches all pads, shifts BUTTONS bits per pad MSB first,
// and publishes a per-frame snapshot plus sticky "pressed since clear" flags.
module controller_hub_m #(
    parameter int unsigned NUM_CONTROLLERS = 2,
    parameter int unsigned BUTTONS         = 8
) (
    input  logic            clk,
    input  logic            rst,
    controller_hub_if.slave hub
);
    localparam int unsigned   NB       = NUM_CONTROLLERS * BUTTONS;
    localparam int unsigned   CW       = $clog2(BUTTONS);
    localparam logic [CW-1:0] LAST_BIT = CW'(BUTTONS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LATCH, S_SHIFT, S_DONE} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_pending;
    logic [CW-1:0] r_count;
    logic          r_latch;
    logic          r_busy;
    logic          r_poll_done;
    logic [NB-1:0] r_buttons;
    logic [NB-1:0] r_pressed;
    logic [NB-1:0] w_shift;
    logic [NB-1:0] w_clear_mask;
    logic [NB-1:0] w_set_mask;
    logic          w_tick;
    logic          w_start;
    logic          w_sample;
    logic          w_last;
    logic          w_leave_done;

    assign w_tick       = hub.clk_in_enable;
    assign w_start      = (r_state == S_IDLE) && w_tick && r_pending;
    assign w_sample     = (r_state == S_SHIFT) && w_tick;
    assign w_last       = (r_count == LAST_BIT);
    assign w_leave_done = (r_state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_start)             w_state_next = S_LATCH;
            S_LATCH: if (w_tick)              w_state_next = S_SHIFT;
            S_SHIFT: if (w_sample && w_last)  w_state_next = S_DONE;
            S_DONE:                           w_state_next = S_IDLE;
            default:                          w_state_next = S_IDLE;
        endcase
    end

    // Shift strobe follows the sample so a pad only advances after its bit was captured.
    always_comb begin
        hub.controller_clk_out_enable = 1'b0;
        w_set_mask                    = '0;
        if (w_sample && !w_last) hub.controller_clk_out_enable = 1'b1;
        if (w_leave_done)        w_set_mask = w_shift & ~r_buttons;
    end

    // A request arriving on the consuming edge re-arms, so at most one extra poll follows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_pending <= 1'b0;
        else if (hub.poll_start)  r_pending <= 1'b1;
        else if (w_start)         r_pending <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              r_count <= '0;
        else if (r_state == S_LATCH && w_tick) r_count <= '0;
        else if (w_sample && !w_last)          r_count <= r_count + CW'(1);
    end

    for (genvar g = 0; g < NUM_CONTROLLERS; g++) begin : g_pad
        logic [BUTTONS-1:0] r_pad_shift;

        always_ff @(posedge clk or posedge rst) begin
            if (rst)           r_pad_shift <= '0;
            else if (w_sample) r_pad_shift <= {r_pad_shift[BUTTONS-2:0], ~hub.data_in_B[g]};
        end

        assign w_shift[g*BUTTONS +: BUTTONS]      = r_pad_shift;
        assign w_clear_mask[g*BUTTONS +: BUTTONS] = {BUTTONS{hub.clear[g]}};
    end

    // Set-after-clear ordering keeps a press that lands on a clear edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_latch     <= 1'b0;
            r_busy      <= 1'b0;
            r_poll_done <= 1'b0;
            r_buttons   <= '0;
            r_pressed   <= '0;
        end else begin
            r_latch     <= (w_state_next == S_LATCH);
            r_busy      <= (w_state_next != S_IDLE);
            r_poll_done <= w_leave_done;
            if (w_leave_done) r_buttons <= w_shift;
            r_pressed   <= (r_pressed & ~w_clear_mask) | w_set_mask;
        end
    end

    assign hub.controller_latch = r_latch;
    assign hub.busy             = r_busy;
    assign hub.poll_done        = r_poll_done;
    assign hub.buttons_out      = r_buttons;
    assign hub.pressed_out      = r_pressed;
endmodule

// File: tb/tb_controller_hub_m.sv
// Bench for controller_hub_m: behavioural NES pads, random tick spacing, frame-level
// reference model of snapshot and sticky flags, two parameterisations side by side.
module tb_controller_hub_m;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    controller_hub_if #(.NUM_CONTROLLERS(2), .BUTTONS(8))  if0 ();
    controller_hub_if #(.NUM_CONTROLLERS(4), .BUTTONS(12)) if1 ();

    controller_hub_m #(.NUM_CONTROLLERS(2), .BUTTONS(8))  dut0 (.clk(clk), .rst(rst), .hub(if0));
    controller_hub_m #(.NUM_CONTROLLERS(4), .BUTTONS(12)) dut1 (.clk(clk), .rst(rst), .hub(if1));

    // Pad shift registers: load while latch is high, advance on the shift strobe.
    logic [7:0]  pad0_val [2];
    logic [7:0]  pad0_sr  [2];
    logic [11:0] pad1_val [3];
    logic [11:0] pad1_sr  [3];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (if0.controller_latch)               pad0_sr[i] <= pad0_val[i];
            else if (if0.controller_clk_out_enable) pad0_sr[i] <= {pad0_sr[i][6:0], 1'b0};
        end
        for (int i = 0; i < 3; i++) begin
            if (if1.controller_latch)               pad1_sr[i] <= pad1_val[i];
            else if (if1.controller_clk_out_enable) pad1_sr[i] <= {pad1_sr[i][10:0], 1'b0};
        end
    end

    assign if0.data_in_B = ~{pad0_sr[1][7], pad0_sr[0][7]};
    assign if1.data_in_B = {1'b1, ~pad1_sr[2][11], ~pad1_sr[1][11], ~pad1_sr[0][11]};

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_oe0, n_lat0, n_done0, n_oe1, n_lat1, n_done1;
    logic        pl0, pl1;
    bit          last0;
    logic [15:0] m_btn0, m_prs0;
    logic [47:0] m_btn1, m_prs1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clk cycle with a random tick; counts strobes before the edge, latch/done after it.
    task automatic step();
        bit tk;
        tk = ($urandom_range(0, 1) == 1);
        if0.clk_in_enable = tk;
        if1.clk_in_enable = tk;
        #1;
        last0 = tk && if0.busy && !if0.controller_clk_out_enable && (n_oe0 == 7);
        if (if0.controller_clk_out_enable) n_oe0++;
        if (if1.controller_clk_out_enable) n_oe1++;
        @(posedge clk);
        #2;
        if (if0.controller_latch && !pl0) n_lat0++;
        if (if1.controller_latch && !pl1) n_lat1++;
        pl0 = if0.controller_latch;
        pl1 = if1.controller_latch;
        if (if0.poll_done) n_done0++;
        if (if1.poll_done) n_done1++;
    endtask

    function automatic logic [15:0] mask0(input logic [1:0] c);
        return {{8{c[1]}}, {8{c[0]}}};
    endfunction

    task automatic do_poll0(input logic [7:0] p0, input logic [7:0] p1,
                            input logic [1:0] clr_done, input string tag);
        int k;
        logic [15:0] nw;
        pad0_val[0] = p0;
        pad0_val[1] = p1;
        n_oe0 = 0; n_lat0 = 0; n_done0 = 0;
        if0.poll_start = 1'b1;
        step();
        if0.poll_start = 1'b0;
        k = 0;
        while (n_done0 == 0 && k < 400) begin
            if0.clear = last0 ? clr_done : 2'b00;
            step();
            k++;
        end
        if0.clear = 2'b00;
        check({tag, "_bounded"}, 64'(k < 400), 64'(1));
        nw     = {p1, p0};
        m_prs0 = (m_prs0 & ~mask0(clr_done)) | (nw & ~m_btn0);
        m_btn0 = nw;
        check({tag, "_done"},    64'(if0.poll_done),   64'(1));
        check({tag, "_busy"},    64'(if0.busy),        64'(0));
        check({tag, "_buttons"}, 64'(if0.buttons_out), 64'(m_btn0));
        check({tag, "_pressed"}, 64'(if0.pressed_out), 64'(m_prs0));
        step();
        step();
        check({tag, "_done_len"}, 64'(n_done0), 64'(1));
        check({tag, "_shifts"},   64'(n_oe0),   64'(7));
        check({tag, "_latches"},  64'(n_lat0),  64'(1));
    endtask

    task automatic clear0(input logic [1:0] c);
        if0.clear = c;
        step();
        if0.clear = 2'b00;
        m_prs0 = m_prs0 & ~mask0(c);
        check("clear_pressed", 64'(if0.pressed_out), 64'(m_prs0));
    endtask

    task automatic do_poll1(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                            input string tag);
        int k;
        logic [47:0] nw;
        pad1_val[0] = a; pad1_val[1] = b; pad1_val[2] = c;
        n_oe1 = 0; n_lat1 = 0; n_done1 = 0;
        if1.poll_start = 1'b1;
        step();
        if1.poll_start = 1'b0;
        k = 0;
        while (n_done1 == 0 && k < 500) begin
            step();
            k++;
        end
        check({tag, "_bounded"}, 64'(k < 500), 64'(1));
        nw     = {12'h000, c, b, a};
        m_prs1 = m_prs1 | (nw & ~m_btn1);
        m_btn1 = nw;
        check({tag, "_buttons"}, 64'(if1.buttons_out), 64'(m_btn1));
        check({tag, "_pressed"}, 64'(if1.pressed_out), 64'(m_prs1));
        step();
        step();
        check({tag, "_done_len"}, 64'(n_done1), 64'(1));
        check({tag, "_shifts"},   64'(n_oe1),   64'(11));
        check({tag, "_latches"},  64'(n_lat1),  64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [15:0] vb;
        rst = 1'b1;
        if0.clk_in_enable = 1'b0; if0.poll_start = 1'b0; if0.clear = '0;
        if1.clk_in_enable = 1'b0; if1.poll_start = 1'b0; if1.clear = '0;
        m_btn0 = '0; m_prs0 = '0; m_btn1 = '0; m_prs1 = '0;
        pl0 = 1'b0; pl1 = 1'b0; last0 = 1'b0;
        n_oe0 = 0; n_lat0 = 0; n_done0 = 0; n_oe1 = 0; n_lat1 = 0; n_done1 = 0;
        @(posedge clk);
        #2;
        step();
        step();
        check("rst_buttons0", 64'(if0.buttons_out), 64'(0));
        check("rst_pressed0", 64'(if0.pressed_out), 64'(0));
        check("rst_busy0",    64'(if0.busy),        64'(0));
        check("rst_done0",    64'(if0.poll_done),   64'(0));
        check("rst_latch0",   64'(if0.controller_latch), 64'(0));
        check("rst_buttons1", 64'(if1.buttons_out), 64'(0));
        check("rst_pressed1", 64'(if1.pressed_out), 64'(0));
        rst = 1'b0;
        step();

        // First poll with the documented pad patterns.
        do_poll0(8'b10001001, 8'b00100110, 2'b00, "poll1");
        check("poll1_const_btn", 64'(if0.buttons_out), 64'(16'b00100110_10001001));
        check("poll1_const_prs", 64'(if0.pressed_out), 64'(16'b00100110_10001001));

        // Sticky flags survive a second poll, then a per-pad clear.
        do_poll0(8'b10001011, 8'b00100110, 2'b00, "poll2");
        vb = if0.pressed_out;
        check("poll2_btn_lo", 64'(if0.buttons_out[7:0]), 64'(8'b10001011));
        check("poll2_prs_lo", 64'(vb[7:0]), 64'(8'b10001011));
        clear0(2'b01);
        vb = if0.pressed_out;
        check("clr0_lo", 64'(vb[7:0]),  64'(0));
        check("clr0_hi", 64'(vb[15:8]), 64'(8'b00100110));

        // Clear on the edge leaving DONE while bit 1 is newly pressed.
        do_poll0(8'b10001001, 8'b00100110, 2'b00, "release");
        do_poll0(8'b10001011, 8'b00100110, 2'b01, "setwins");
        vb = if0.pressed_out;
        check("setwins_bit1", 64'(vb[1]), 64'(1));

        // Three requests during SHIFT coalesce into one extra poll.
        pad0_val[0] = 8'($urandom);
        pad0_val[1] = 8'($urandom);
        n_oe0 = 0; n_lat0 = 0; n_done0 = 0;
        if0.poll_start = 1'b1;
        step();
        if0.poll_start = 1'b0;
        k = 0;
        while (n_oe0 < 1 && k < 400) begin step(); k++; end
        check("coal_reach_shift", 64'(k < 400), 64'(1));
        for (int j = 0; j < 3; j++) begin
            if0.poll_start = 1'b1;
            step();
            if0.poll_start = 1'b0;
            if (j < 2) step();
        end
        k = 0;
        while (n_done0 < 2 && k < 800) begin step(); k++; end
        check("coal_bounded", 64'(k < 800), 64'(1));
        for (int j = 0; j < 60; j++) step();
        m_prs0 = m_prs0 | ({pad0_val[1], pad0_val[0]} & ~m_btn0);
        m_btn0 = {pad0_val[1], pad0_val[0]};
        check("coal_polls",   64'(n_done0), 64'(2));
        check("coal_latches", 64'(n_lat0),  64'(2));
        check("coal_shifts",  64'(n_oe0),   64'(14));
        check("coal_buttons", 64'(if0.buttons_out), 64'(m_btn0));
        check("coal_pressed", 64'(if0.pressed_out), 64'(m_prs0));

        // Reset in the middle of SHIFT aborts the poll.
        pad0_val[0] = 8'($urandom);
        pad0_val[1] = 8'($urandom);
        n_oe0 = 0; n_done0 = 0;
        if0.poll_start = 1'b1;
        step();
        if0.poll_start = 1'b0;
        k = 0;
        while (n_oe0 < 3 && k < 400) begin step(); k++; end
        check("rstmid_reach_shift", 64'(k < 400), 64'(1));
        rst = 1'b1;
        #1;
        check("rstmid_latch",   64'(if0.controller_latch),          64'(0));
        check("rstmid_oe",      64'(if0.controller_clk_out_enable), 64'(0));
        check("rstmid_buttons", 64'(if0.buttons_out),               64'(0));
        check("rstmid_pressed", 64'(if0.pressed_out),               64'(0));
        check("rstmid_busy",    64'(if0.busy),                      64'(0));
        check("rstmid_done",    64'(if0.poll_done),                 64'(0));
        #1;
        step();
        step();
        rst = 1'b0;
        m_btn0 = '0; m_prs0 = '0; m_btn1 = '0; m_prs1 = '0;
        n_done0 = 0;
        for (int j = 0; j < 30; j++) step();
        check("rstmid_no_done", 64'(n_done0), 64'(0));
        check("rstmid_idle",    64'(if0.busy), 64'(0));
        do_poll0(8'($urandom), 8'($urandom), 2'b00, "after_rst");

        // Random frames with random clears at DONE and in between.
        for (int j = 0; j < 4; j++) begin
            do_poll0(8'($urandom), 8'($urandom), 2'($urandom), "rnd");
            if ($urandom_range(0, 1) == 1) clear0(2'($urandom));
        end

        // Wider configuration: pad3 absent, pad2 fixed.
        do_poll1(12'($urandom), 12'($urandom), 12'hA5C, "wide1");
        check("wide1_pad3", 64'(if1.buttons_out[47:36]), 64'(0));
        check("wide1_pad2", 64'(if1.buttons_out[35:24]), 64'(12'hA5C));
        do_poll1(12'($urandom), 12'($urandom), 12'($urandom), "wide2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
